ap_unit_registers: RTL and testbench
====================================

Name: ap_unit_registers

Overview:
- Register file and sample buffer for the APU audio playback unit. This is the output-direction counterpart of the capture unit.
- The CPU writes 16-bit PCM samples and configuration over the register bus. The playback interface (PWM/PDM modulator) pulls samples on request.
- A FIFO decouples the two sides. Programmable events raise an edge-triggered interrupt on empty, low level, underrun or full.

Parameters:
- BUFFER_SIZE, 512, FIFO depth in samples. Power of two, 2..32768.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  synchronous active-low reset
- interrupt_o  out  1  one-cycle pulse on any event rising edge
- request_i  in  1  playback interface requests the next sample
- pcm_sample_o  out  16  sample delivered to the interface
- valid_o  out  1  pcm_sample_o valid; one-cycle pulse
- divisor_o  out  7  modulator clock divisor
- gain_o  out  16  playback gain, Q1.15
- enable_interface_o  out  1  playback interface enable
- dual_channel_o  out  1  stereo mode
- channel_o  out  1  selected channel in mono mode
- write_i  in  1  bus write
- write_address_i  in  playback_unit_registers_t  write register select
- write_data_i  in  4x8  write data
- write_strobe_i  in  4  byte strobes
- write_error_o  out  1  write error, combinational
- read_i  in  1  bus read
- read_address_i  in  playback_unit_registers_t  read register select
- read_data_o  out  32  read data, combinational
- read_error_o  out  1  read error, combinational

Behaviour:
- Reset is synchronous: rst_n_i low at a clock edge applies all reset values.
- playback_unit_registers_t lives in apu_pkg: STATUS=0, CONTROL=1, GAIN=2, SAMPLE_BUFFER=3, WATERMARK=4, EVENT=5.
- CONTROL register:
  - bits[6:0] clock_divisor (strobe0)
  - bits[11:8] interrupt_enable[3:0] (strobe1)
  - bit12 channel, bit13 dual_channel, bit14 buffer_enable (strobe1)
  - bit16 interface_enable (strobe2)
  - Reset value 0. Unused bits read 0.
- GAIN register: 16 bits, byte-strobed, reset 16'h8000.
- WATERMARK register: $clog2(BUFFER_SIZE)+1 bits, strobes 0/1, reset 0.
- STATUS register (read-only):
  - bit0 empty, bit1 full
  - bits[31:16] current FIFO level, zero-extended
- Config outputs mirror their register fields directly. Reset values: divisor_o, enable_interface_o, dual_channel_o, channel_o = 0; gain_o = 16'h8000.
- Push to FIFO:
  - Condition: write_i, address SAMPLE_BUFFER, buffer_enable=1, not full.
  - Data pushed is write_data_i[1:0] as a 16-bit sample. Strobes are ignored.
  - Write with buffer_enable=0: silently dropped, no error.
- Pop from FIFO:
  - Pop occurs when request_i, enable_interface_o=1 and FIFO not empty.
  - request_i while enable_interface_o=0 is ignored: no valid_o, no event.
  - On the next cycle, pcm_sample_o = popped head sample and valid_o=1 for one cycle.
  - request_i while enabled and empty is an underrun: next cycle pcm_sample_o=16'h0000, valid_o=1.
  - pcm_sample_o holds its value between pulses. Reset: pcm_sample_o=0, valid_o=0.
- Simultaneous push and pop:
  - Not full, not empty: both happen; level unchanged.
  - Full: pop happens, push is rejected (flagged as a write error); level decrements.
  - Empty: underrun is reported; push is stored; level becomes 1.
- Pointers wrap modulo BUFFER_SIZE. The level counter saturates logically at BUFFER_SIZE, which means full.
- write_error_o:
  - Asserted for: write_i to STATUS; write_i to SAMPLE_BUFFER while full with buffer_enable=1; write_i to an undefined address.
  - A rejected write changes no state.
- read_error_o: asserted for read_i to SAMPLE_BUFFER (write-only, reads 0) or to an undefined address.
- EVENT register: 4 sticky bits. Each sets when its condition holds and the matching interrupt_enable bit is 1.
  - [0] FIFO empty, level 0, not during reset.
  - [1] level < watermark.
  - [2] underrun.
  - [3] FIFO full.
- EVENT write (strobe0) replaces bits with write_data_i[0][3:0]. The write has priority over sets in the same cycle.
- interrupt_o = OR over i of (event[i] & ~event_q[i]), where event_q is event delayed one cycle. Reset: event and event_q = 0.
- Reads are combinational with no side effects; undefined addresses return 0.
- Reset mid-operation: FIFO flushed (level 0), in-flight sample discarded, all registers return to reset values.

Test Plan:
- Reset check: reset, then read all registers -> CONTROL=0, GAIN=0x00008000, STATUS=0x00000001 (empty, level 0), EVENT=0, all outputs at reset values.
- Basic playback: set buffer_enable and interface_enable; push 0x1234, 0xABCD; request_i twice -> valid_o pulses one cycle after each request, with 0x1234 then 0xABCD; STATUS ends 0x00000001.
- Underrun event: set interrupt_enable[2]; request_i on empty FIFO -> pcm_sample_o=0, valid_o=1, EVENT[2]=1, interrupt_o single pulse. Write EVENT=0 -> EVENT clears.
- Full FIFO: push BUFFER_SIZE samples -> STATUS full=1 with level 512; 513th push -> write_error_o=1 and level stays 512. Push plus pop on the same cycle while full -> level 511, push rejected.
- Watermark: WATERMARK=4, interrupt_enable[1]=1, FIFO holds 5 samples; pop one sample -> EVENT[1] stays 0; pop a second -> EVENT[1]=1 with one interrupt_o pulse, and no further pulse while EVENT[1] stays set.
- Bus errors and reset: write to STATUS -> write_error_o=1; read SAMPLE_BUFFER -> read_error_o=1 with data 0. Assert reset with 10 samples buffered -> level 0 and empty=1.

Source files
------------

// File: rtl/ap_unit_registers.sv
// APU playback register file: CPU-written configuration plus a sample FIFO
// drained by the PWM/PDM modulator, with sticky events and an edge interrupt.

package apu_pkg;
  typedef enum logic [2:0] {
    STATUS        = 3'd0,
    CONTROL       = 3'd1,
    GAIN          = 3'd2,
    SAMPLE_BUFFER = 3'd3,
    WATERMARK     = 3'd4,
    EVENT         = 3'd5
  } playback_unit_registers_t;
endpackage

module ap_unit_registers
  import apu_pkg::*;
#(
  parameter int BUFFER_SIZE = 512
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  output logic                     interrupt_o,
  input  logic                     request_i,
  output logic [15:0]              pcm_sample_o,
  output logic                     valid_o,
  output logic [6:0]               divisor_o,
  output logic [15:0]              gain_o,
  output logic                     enable_interface_o,
  output logic                     dual_channel_o,
  output logic                     channel_o,
  input  logic                     write_i,
  input  playback_unit_registers_t write_address_i,
  input  logic [3:0][7:0]          write_data_i,
  input  logic [3:0]               write_strobe_i,
  output logic                     write_error_o,
  input  logic                     read_i,
  input  playback_unit_registers_t read_address_i,
  output logic [31:0]              read_data_o,
  output logic                     read_error_o
);

  localparam int AW = $clog2(BUFFER_SIZE);
  localparam int LW = AW + 1;

  logic [6:0]    clock_divisor;
  logic [3:0]    interrupt_enable;
  logic          channel, dual_channel, buffer_enable, interface_enable;
  logic [15:0]   gain;
  logic [LW-1:0] watermark, watermark_next;
  logic [3:0]    events, events_q, event_cond;
  logic [LW-1:0] level;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [15:0]   mem [BUFFER_SIZE];
  logic [15:0]   pcm_sample;
  logic          valid;
  logic [31:0]   write_data_flat;

  logic empty, full, write_ok, push, pop_req, pop, underrun;

  assign write_data_flat = write_data_i;
  assign empty = (level == '0);
  assign full  = (level == LW'(BUFFER_SIZE));

  always_comb begin
    write_error_o = 1'b0;
    if (write_i) begin
      case (write_address_i)
        STATUS:                          write_error_o = 1'b1;
        SAMPLE_BUFFER:                   write_error_o = buffer_enable && full;
        CONTROL, GAIN, WATERMARK, EVENT: write_error_o = 1'b0;
        default:                         write_error_o = 1'b1;
      endcase
    end
  end

  // A rejected write must not touch any state, so every update keys off write_ok.
  assign write_ok = write_i && !write_error_o;
  assign push     = write_ok && (write_address_i == SAMPLE_BUFFER) && buffer_enable;
  assign pop_req  = request_i && interface_enable;
  assign pop      = pop_req && !empty;
  assign underrun = pop_req && empty;

  always_comb begin
    watermark_next = watermark;
    for (int b = 0; b < LW; b++) begin
      if (write_strobe_i[b / 8]) watermark_next[b] = write_data_flat[b];
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= {write_data_i[1], write_data_i[0]};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      pcm_sample <= 16'h0000;
      valid      <= 1'b0;
    end else begin
      valid <= pop_req;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr     <= rd_ptr + AW'(1);
        pcm_sample <= mem[rd_ptr];
      end else if (underrun) begin
        pcm_sample <= 16'h0000;
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      clock_divisor    <= '0;
      interrupt_enable <= '0;
      channel          <= 1'b0;
      dual_channel     <= 1'b0;
      buffer_enable    <= 1'b0;
      interface_enable <= 1'b0;
      gain             <= 16'h8000;
      watermark        <= '0;
    end else if (write_ok) begin
      case (write_address_i)
        CONTROL: begin
          if (write_strobe_i[0]) clock_divisor <= write_data_i[0][6:0];
          if (write_strobe_i[1]) begin
            interrupt_enable <= write_data_i[1][3:0];
            channel          <= write_data_i[1][4];
            dual_channel     <= write_data_i[1][5];
            buffer_enable    <= write_data_i[1][6];
          end
          if (write_strobe_i[2]) interface_enable <= write_data_i[2][0];
        end
        GAIN: begin
          if (write_strobe_i[0]) gain[7:0]  <= write_data_i[0];
          if (write_strobe_i[1]) gain[15:8] <= write_data_i[1];
        end
        WATERMARK: watermark <= watermark_next;
        default: ;
      endcase
    end
  end

  assign event_cond = {full, underrun, (level < watermark), empty};

  // Software writes to EVENT win over hardware sets landing in the same cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      events   <= '0;
      events_q <= '0;
    end else begin
      events_q <= events;
      if (write_ok && (write_address_i == EVENT) && write_strobe_i[0])
        events <= write_data_i[0][3:0];
      else
        events <= events | (event_cond & interrupt_enable);
    end
  end

  assign interrupt_o = |(events & ~events_q);

  always_comb begin
    read_data_o  = 32'h0;
    read_error_o = 1'b0;
    case (read_address_i)
      STATUS:        read_data_o = {16'(level), 14'b0, full, empty};
      CONTROL:       read_data_o = {15'b0, interface_enable, 1'b0, buffer_enable, dual_channel,
                                    channel, interrupt_enable, 1'b0, clock_divisor};
      GAIN:          read_data_o = {16'h0, gain};
      WATERMARK:     read_data_o = 32'(watermark);
      EVENT:         read_data_o = {28'h0, events};
      SAMPLE_BUFFER: read_error_o = read_i;
      default:       read_error_o = read_i;
    endcase
  end

  assign pcm_sample_o       = pcm_sample;
  assign valid_o            = valid;
  assign divisor_o          = clock_divisor;
  assign gain_o             = gain;
  assign enable_interface_o = interface_enable;
  assign dual_channel_o     = dual_channel;
  assign channel_o          = channel;

endmodule

// File: tb/tb_ap_unit_registers.sv
// Directed bench for ap_unit_registers: register defaults, playback, underrun,
// full FIFO, watermark interrupt, bus errors and mid-operation reset.

module tb_ap_unit_registers;
  import apu_pkg::*;

  logic                     clk_i = 1'b0;
  logic                     rst_n_i = 1'b0;
  logic                     interrupt_o;
  logic                     request_i = 1'b0;
  logic [15:0]              pcm_sample_o;
  logic                     valid_o;
  logic [6:0]               divisor_o;
  logic [15:0]              gain_o;
  logic                     enable_interface_o;
  logic                     dual_channel_o;
  logic                     channel_o;
  logic                     write_i = 1'b0;
  playback_unit_registers_t write_address_i = STATUS;
  logic [3:0][7:0]          write_data_i = '0;
  logic [3:0]               write_strobe_i = '0;
  logic                     write_error_o;
  logic                     read_i = 1'b0;
  playback_unit_registers_t read_address_i = STATUS;
  logic [31:0]              read_data_o;
  logic                     read_error_o;

  int checks = 0;
  int errors = 0;
  logic        wrErr;
  logic [31:0] rdData;
  logic        rdErr;
  int          irqCount;

  ap_unit_registers #(.BUFFER_SIZE(512)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .interrupt_o(interrupt_o), .request_i(request_i),
    .pcm_sample_o(pcm_sample_o), .valid_o(valid_o), .divisor_o(divisor_o), .gain_o(gain_o),
    .enable_interface_o(enable_interface_o), .dual_channel_o(dual_channel_o),
    .channel_o(channel_o), .write_i(write_i), .write_address_i(write_address_i),
    .write_data_i(write_data_i), .write_strobe_i(write_strobe_i),
    .write_error_o(write_error_o), .read_i(read_i), .read_address_i(read_address_i),
    .read_data_o(read_data_o), .read_error_o(read_error_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One-cycle bus write; write_error_o is captured before the clock edge.
  task automatic applyStimulus(input playback_unit_registers_t addr, input logic [31:0] data,
                               input logic [3:0] strobe);
    @(negedge clk_i);
    write_i = 1'b1;
    write_address_i = addr;
    write_data_i = data;
    write_strobe_i = strobe;
    #1 wrErr = write_error_o;
    @(posedge clk_i);
    #1 write_i = 1'b0;
    write_strobe_i = '0;
  endtask

  task automatic busRead(input playback_unit_registers_t addr);
    @(negedge clk_i);
    read_i = 1'b1;
    read_address_i = addr;
    #1 rdData = read_data_o;
    rdErr = read_error_o;
    read_i = 1'b0;
  endtask

  task automatic requestPulse();
    @(negedge clk_i);
    request_i = 1'b1;
    @(posedge clk_i);
    #1 request_i = 1'b0;
  endtask

  task automatic countInterrupts(input int cycles);
    irqCount = 0;
    repeat (cycles) begin
      @(negedge clk_i);
      if (interrupt_o) irqCount++;
    end
  endtask

  task automatic doReset();
    @(negedge clk_i);
    rst_n_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_n_i = 1'b1;
  endtask

  initial begin
    $display("[TB] start");
    doReset();

    // Reset values
    busRead(CONTROL);   checkOutput("reset CONTROL", rdData, 32'h0);
    busRead(GAIN);      checkOutput("reset GAIN", rdData, 32'h0000_8000);
    busRead(STATUS);    checkOutput("reset STATUS", rdData, 32'h0000_0001);
    busRead(EVENT);     checkOutput("reset EVENT", rdData, 32'h0);
    busRead(WATERMARK); checkOutput("reset WATERMARK", rdData, 32'h0);
    checkOutput("reset gain_o", 32'(gain_o), 32'h8000);
    checkOutput("reset outputs", {valid_o, interrupt_o, enable_interface_o, dual_channel_o, channel_o, divisor_o},
                32'h0);
    checkOutput("reset pcm", 32'(pcm_sample_o), 32'h0);

    // Basic playback
    applyStimulus(CONTROL, 32'h0001_4005, 4'b0111);
    checkOutput("ctrl divisor_o", 32'(divisor_o), 32'h5);
    checkOutput("ctrl enable_if", 32'(enable_interface_o), 32'h1);
    busRead(CONTROL); checkOutput("ctrl readback", rdData, 32'h0001_4005);
    applyStimulus(GAIN, 32'h0000_3456, 4'b0001);
    checkOutput("gain low byte", 32'(gain_o), 32'h8056);
    applyStimulus(SAMPLE_BUFFER, 32'h0000_1234, 4'b0000);
    applyStimulus(SAMPLE_BUFFER, 32'h0000_ABCD, 4'b0000);
    busRead(STATUS); checkOutput("play level2", rdData, 32'h0002_0000);
    requestPulse();
    checkOutput("play valid1", 32'(valid_o), 32'h1);
    checkOutput("play sample1", 32'(pcm_sample_o), 32'h1234);
    @(posedge clk_i); #1;
    checkOutput("play valid pulse", 32'(valid_o), 32'h0);
    checkOutput("play hold", 32'(pcm_sample_o), 32'h1234);
    requestPulse();
    checkOutput("play sample2", {15'b0, valid_o, pcm_sample_o}, 32'h0001_ABCD);
    busRead(STATUS); checkOutput("play empty", rdData, 32'h0000_0001);

    // Underrun event
    applyStimulus(CONTROL, 32'h0001_4405, 4'b0111);
    requestPulse();
    checkOutput("underrun sample", {15'b0, valid_o, pcm_sample_o}, 32'h0001_0000);
    checkOutput("underrun irq", 32'(interrupt_o), 32'h1);
    @(posedge clk_i); #1;
    checkOutput("underrun irq pulse", 32'(interrupt_o), 32'h0);
    busRead(EVENT); checkOutput("underrun EVENT", rdData, 32'h4);
    applyStimulus(EVENT, 32'h0, 4'b0001);
    busRead(EVENT); checkOutput("EVENT cleared", rdData, 32'h0);

    // Watermark event
    applyStimulus(WATERMARK, 32'h0000_0004, 4'b0011);
    for (int i = 0; i < 5; i++) applyStimulus(SAMPLE_BUFFER, 32'(16'h0011 + i), 4'b0000);
    applyStimulus(CONTROL, 32'h0001_4205, 4'b0111);
    requestPulse();
    checkOutput("wm pop1", 32'(pcm_sample_o), 32'h0011);
    countInterrupts(4);
    checkOutput("wm no irq at level4", 32'(irqCount), 32'h0);
    busRead(EVENT); checkOutput("wm EVENT clear", rdData, 32'h0);
    requestPulse();
    checkOutput("wm pop2", 32'(pcm_sample_o), 32'h0012);
    countInterrupts(6);
    checkOutput("wm one irq", 32'(irqCount), 32'h1);
    busRead(EVENT); checkOutput("wm EVENT set", rdData, 32'h2);

    // Full FIFO
    doReset();
    applyStimulus(CONTROL, 32'h0001_4005, 4'b0111);
    for (int i = 0; i < 512; i++) applyStimulus(SAMPLE_BUFFER, 32'(16'h0100 + i), 4'b0000);
    busRead(STATUS); checkOutput("full STATUS", rdData, 32'h0200_0002);
    applyStimulus(SAMPLE_BUFFER, 32'h0000_BEEF, 4'b0011);
    checkOutput("full push error", 32'(wrErr), 32'h1);
    busRead(STATUS); checkOutput("full level kept", rdData, 32'h0200_0002);
    @(negedge clk_i);
    write_i = 1'b1;
    write_address_i = SAMPLE_BUFFER;
    write_data_i = 32'h0000_DEAD;
    request_i = 1'b1;
    #1 checkOutput("full push+pop error", 32'(write_error_o), 32'h1);
    @(posedge clk_i);
    #1 write_i = 1'b0;
    request_i = 1'b0;
    checkOutput("full pop sample", {15'b0, valid_o, pcm_sample_o}, 32'h0001_0100);
    busRead(STATUS); checkOutput("full level 511", rdData, 32'h01FF_0000);
    requestPulse();
    checkOutput("full pop order", 32'(pcm_sample_o), 32'h0101);

    // Bus errors
    applyStimulus(STATUS, 32'hFFFF_FFFF, 4'b1111);
    checkOutput("wr STATUS error", 32'(wrErr), 32'h1);
    applyStimulus(playback_unit_registers_t'(3'd6), 32'h1, 4'b1111);
    checkOutput("wr undefined error", 32'(wrErr), 32'h1);
    applyStimulus(GAIN, 32'h0000_1111, 4'b0011);
    checkOutput("wr GAIN no error", 32'(wrErr), 32'h0);
    busRead(SAMPLE_BUFFER);
    checkOutput("rd SAMPLE_BUFFER", {rdErr, rdData[30:0]}, 32'h8000_0000);
    busRead(playback_unit_registers_t'(3'd7));
    checkOutput("rd undefined", {rdErr, rdData[30:0]}, 32'h8000_0000);
    busRead(STATUS);
    checkOutput("rd STATUS ok", {31'b0, rdErr}, 32'h0);

    // Reset mid-operation
    doReset();
    applyStimulus(CONTROL, 32'h0001_4005, 4'b0111);
    for (int i = 0; i < 10; i++) applyStimulus(SAMPLE_BUFFER, 32'(16'h0200 + i), 4'b0000);
    requestPulse();
    checkOutput("pre-reset sample", 32'(pcm_sample_o), 32'h0200);
    busRead(STATUS); checkOutput("pre-reset level", rdData, 32'h0009_0000);
    doReset();
    busRead(STATUS); checkOutput("post-reset STATUS", rdData, 32'h0000_0001);
    busRead(CONTROL); checkOutput("post-reset CONTROL", rdData, 32'h0);
    checkOutput("post-reset pcm", {15'b0, valid_o, pcm_sample_o}, 32'h0);
    checkOutput("post-reset gain_o", 32'(gain_o), 32'h8000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
